dsp_file_responder: RTL and testbench
=====================================

Name: dsp_file_responder

Overview:
- Responder end of the DSP equation file interface.
- Serves `file_read`, `file_write` and `file_reset` requests from the DSP equation engines against NUM_FILES independent circular word buffers held in internal memory.
- Returns `file_read_data` and per-file `rd_ptr`/`wr_ptr`.
- Signals busy via `file_active` and flags illegal accesses via `error`.

Parameters:
- dw, 32, data word width
- NUM_FILES, 4, number of independent file buffers (power of 2, max 256)
- DEPTH, 16, words per file (power of 2, 2..256)

Ports:
- wb_clk  input  1  system clock, all logic rising-edge
- wb_rst_n  input  1  asynchronous active-low reset
- file_num  input  8  file selector for the request and for the pointer outputs
- file_write  input  1  write request, sampled in IDLE
- file_read  input  1  read request, sampled in IDLE
- file_reset  input  1  clear selected file's pointers, sampled in IDLE
- file_rd_ptr_offset  input  32  read address offset from rd_ptr (mod DEPTH)
- file_write_data  input  dw  write data
- hold_rd_ptr  input  1  1 = read does not advance rd_ptr (peek)
- file_read_data  output  dw  read result
- file_active  output  1  responder busy
- error  output  1  one-cycle error pulse
- rd_ptr  output  32  read pointer of file `file_num`, zero-extended
- wr_ptr  output  32  write pointer of file `file_num`, zero-extended
- file_count  output  9  words held in file `file_num`

Behaviour:
- Reset (async, wb_rst_n=0):
  - All outputs 0.
  - State IDLE.
  - All per-file rd_ptr, wr_ptr and count = 0.
  - Memory contents undefined.
  - Reset mid-transaction aborts the transaction with no memory write.
- FSM states:
  - IDLE → ACCEPT: on file_write | file_read.
  - ACCEPT → ACCESS: unconditional.
  - ACCESS → IDLE: unconditional.
- ACCEPT: latch file_num, file_write_data, hold_rd_ptr, offset and operation.
- file_active: 1 in ACCEPT and ACCESS, i.e. exactly 2 cycles starting the cycle after the request; 0 in IDLE.
- Request sampling:
  - Requests are sampled only in IDLE; requests while file_active=1 are ignored.
  - Initiator holds or re-pulses a request; a request still high in the IDLE cycle after completion starts a new transaction.
- Priority in IDLE, same cycle: file_reset > file_write > file_read. The lower-priority requests are dropped silently.
- file_reset: single cycle in IDLE. Clears rd_ptr, wr_ptr and count of file_num; file_active stays 0; no error.
- Write (in ACCESS):
  - count==DEPTH: error=1, no state change.
  - Otherwise: mem[num][wr_ptr]=data; wr_ptr=(wr_ptr+1) mod DEPTH; count+1.
- Read (in ACCESS):
  - Address = (rd_ptr + offset) mod DEPTH; only the low log2(DEPTH) bits of offset are used.
  - offset ≥ count (including empty): file_read_data=0, error=1, pointers unchanged.
  - Otherwise: file_read_data=mem[addr]. If hold_rd_ptr=0: rd_ptr=(rd_ptr+1) mod DEPTH and count−1. If hold_rd_ptr=1: no change.
- file_num ≥ NUM_FILES on any request: error=1 in ACCESS, no state change. For file_reset the error pulses in the same cycle.
- file_read_data: updates at the end of ACCESS, valid from the cycle file_active falls, held until the next successful or failed read. Writes do not alter it.
- error: high only during the ACCESS cycle of the failing transaction.
- Pointer outputs:
  - rd_ptr, wr_ptr and file_count are combinational muxes of the per-file registers indexed by the live file_num.
  - An out-of-range file_num gives 0.
  - They update the cycle after ACCESS.
- Wrap: when count==DEPTH, wr_ptr equals rd_ptr; full and empty are distinguished only by count.
- Memory: inferred synchronous RAM of NUM_FILES*DEPTH words, address {num, ptr}. One port, one access per transaction.

Test Plan:
- Basic write/read:
  - Stimulus: reset; write 0xA5A50001, 0xA5A50002, 0xA5A50003 to file 1; then 3 reads with hold=0, offset=0.
  - Required: file_active 2 cycles per request; reads return the 3 words in order; file 1 wr_ptr=3, rd_ptr=3, count=0; file 0 pointers remain 0.
- Full:
  - Stimulus: write 16 words to file 0, then a 17th write of 0xDEADBEEF.
  - Required: error pulses once; wr_ptr=0 (wrapped); count=16; a subsequent read returns word 0, not 0xDEADBEEF.
- Peek with offset:
  - Stimulus: file 2 holds 0x10, 0x20, 0x30; read with hold_rd_ptr=1, offset=2.
  - Required: 0x30; rd_ptr and count unchanged.
- Offset out of range:
  - Stimulus: read of file 2 with offset=3.
  - Required: file_read_data=0, error=1.
- Empty and illegal file:
  - Stimulus: read of empty file 3; then write to file_num=5.
  - Required: both give error=1; read data=0; no pointer changes.
- Priority, busy and reset:
  - Stimulus: file_reset+file_write same cycle on file 1 holding 2 words; a write during file_active; wb_rst_n low during ACCEPT.
  - Required: file 1 count=0 and no write; the busy write is ignored; after reset all outputs 0, file_active=0, and a following read of that file errors.

Source files
------------

// File: rtl/dsp_file_responder_if.sv
// Equation-file request/response bundle between a DSP equation engine
// (master) and the file responder (slave).
//   file_num            : file selector for the request and the pointer outputs
//   file_write/read     : transfer requests, sampled while the responder is idle
//   file_reset          : clear the selected file's pointers
//   file_rd_ptr_offset  : read address offset from rd_ptr (mod DEPTH)
//   file_write_data     : write data
//   hold_rd_ptr         : 1 = read peeks without consuming
//   file_read_data      : read result
//   file_active         : responder busy
//   error               : one-cycle illegal-access pulse
//   rd_ptr/wr_ptr       : pointers of file file_num, zero-extended
//   file_count          : words held in file file_num
interface dsp_file_responder_if #(
  parameter int dw = 32
);
  logic [7:0]    file_num;
  logic          file_write;
  logic          file_read;
  logic          file_reset;
  logic [31:0]   file_rd_ptr_offset;
  logic [dw-1:0] file_write_data;
  logic          hold_rd_ptr;
  logic [dw-1:0] file_read_data;
  logic          file_active;
  logic          error;
  logic [31:0]   rd_ptr;
  logic [31:0]   wr_ptr;
  logic [8:0]    file_count;

  modport master (
    output file_num, file_write, file_read, file_reset,
           file_rd_ptr_offset, file_write_data, hold_rd_ptr,
    input  file_read_data, file_active, error, rd_ptr, wr_ptr, file_count
  );

  modport slave (
    input  file_num, file_write, file_read, file_reset,
           file_rd_ptr_offset, file_write_data, hold_rd_ptr,
    output file_read_data, file_active, error, rd_ptr, wr_ptr, file_count
  );
endinterface

// File: rtl/dsp_file_responder.sv
// Responder for the DSP equation file interface. Holds NUM_FILES independent
// circular word buffers of DEPTH words in one internal RAM and serves
// read/write/reset requests through a three-state IDLE/ACCEPT/ACCESS FSM.
//   wb_clk   : system clock, rising edge
//   wb_rst_n : asynchronous active-low reset
//   bus      : slave side of dsp_file_responder_if (requests in, data,
//              busy, error and per-file pointers out)
module dsp_file_responder #(
  parameter int dw        = 32,
  parameter int NUM_FILES = 4,
  parameter int DEPTH     = 16
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  dsp_file_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, ACCESS} state_t;

  state_t          r_state;
  logic [7:0]      r_num;
  logic [dw-1:0]   r_wdata;
  logic            r_hold;
  logic [AW-1:0]   r_off;
  logic            r_is_write;
  logic            r_active;
  logic            r_error;
  logic [dw-1:0]   r_rdata;
  logic [AW-1:0]   r_rd_ptr [NUM_FILES];
  logic [AW-1:0]   r_wr_ptr [NUM_FILES];
  logic [8:0]      r_count  [NUM_FILES];
  logic [dw-1:0]   r_mem    [NUM_FILES*DEPTH];

  // Transaction-side decode, driven from the latched request.
  logic            w_num_ok;
  logic [NW-1:0]   w_idx;
  logic [AW-1:0]   w_rd_addr;
  logic            w_wr_ok;
  logic            w_rd_ok;

  // Live-selector decode for the pointer outputs and file_reset.
  logic            w_live_ok;
  logic [NW-1:0]   w_live_idx;

  always_comb begin
    w_num_ok  = ({1'b0, r_num} < 9'(NUM_FILES));
    w_idx     = r_num[NW-1:0];
    w_rd_addr = r_rd_ptr[w_idx] + r_off;
    w_wr_ok   = w_num_ok && (r_count[w_idx] != 9'(DEPTH));
    w_rd_ok   = w_num_ok && (9'(r_off) < r_count[w_idx]);
  end

  always_comb begin
    w_live_ok       = ({1'b0, bus.file_num} < 9'(NUM_FILES));
    w_live_idx      = bus.file_num[NW-1:0];
    bus.rd_ptr      = '0;
    bus.wr_ptr      = '0;
    bus.file_count  = '0;
    if (w_live_ok) begin
      bus.rd_ptr     = 32'(r_rd_ptr[w_live_idx]);
      bus.wr_ptr     = 32'(r_wr_ptr[w_live_idx]);
      bus.file_count = r_count[w_live_idx];
    end
  end

  assign bus.file_active    = r_active;
  assign bus.error          = r_error;
  assign bus.file_read_data = r_rdata;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= IDLE;
      r_num      <= '0;
      r_wdata    <= '0;
      r_hold     <= 1'b0;
      r_off      <= '0;
      r_is_write <= 1'b0;
      r_active   <= 1'b0;
      r_error    <= 1'b0;
      r_rdata    <= '0;
      for (int unsigned i = 0; i < NUM_FILES; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.file_reset) begin
            if (w_live_ok) begin
              r_rd_ptr[w_live_idx] <= '0;
              r_wr_ptr[w_live_idx] <= '0;
              r_count[w_live_idx]  <= '0;
            end else begin
              r_error <= 1'b1;
            end
          end else if (bus.file_write || bus.file_read) begin
            r_state    <= ACCEPT;
            r_active   <= 1'b1;
            r_num      <= bus.file_num;
            r_wdata    <= bus.file_write_data;
            r_hold     <= bus.hold_rd_ptr;
            r_off      <= bus.file_rd_ptr_offset[AW-1:0];
            r_is_write <= bus.file_write;
          end
        end
        ACCEPT: begin
          // Error is decided one cycle early so it is high exactly in ACCESS.
          r_state <= ACCESS;
          r_error <= r_is_write ? !w_wr_ok : !w_rd_ok;
        end
        ACCESS: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
          if (r_is_write) begin
            if (w_wr_ok) begin
              r_wr_ptr[w_idx] <= r_wr_ptr[w_idx] + 1'b1;
              r_count[w_idx]  <= r_count[w_idx] + 1'b1;
            end
          end else begin
            r_rdata <= w_rd_ok ? r_mem[{w_idx, w_rd_addr}] : '0;
            if (w_rd_ok && !r_hold) begin
              r_rd_ptr[w_idx] <= r_rd_ptr[w_idx] + 1'b1;
              r_count[w_idx]  <= r_count[w_idx] - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM write port kept free of reset; an asynchronous reset forces
  // r_state to IDLE, which suppresses any pending write.
  always_ff @(posedge wb_clk) begin
    if (r_state == ACCESS && r_is_write && w_wr_ok) begin
      r_mem[{w_idx, r_wr_ptr[w_idx]}] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_dsp_file_responder.sv
// Directed self-checking bench for dsp_file_responder.
module tb_dsp_file_responder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  dsp_file_responder_if #(.dw(32)) bus ();

  dsp_file_responder #(.dw(32), .NUM_FILES(4), .DEPTH(16)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; checks busy for two cycles and the error pulse.
  task automatic do_op(input string tag, input bit wr, input logic [7:0] num,
                       input logic [31:0] wdata, input logic [31:0] off,
                       input bit hold, input bit exp_err);
    bus.file_num           = num;
    bus.file_write         = wr;
    bus.file_read          = !wr;
    bus.file_write_data    = wdata;
    bus.file_rd_ptr_offset = off;
    bus.hold_rd_ptr        = hold;
    step();
    bus.file_write = 1'b0;
    bus.file_read  = 1'b0;
    check({tag, " active@accept"}, 32'(bus.file_active), 32'd1);
    check({tag, " err@accept"},    32'(bus.error),       32'd0);
    step();
    check({tag, " active@access"}, 32'(bus.file_active), 32'd1);
    check({tag, " err@access"},    32'(bus.error),       32'(exp_err));
    step();
    check({tag, " active@idle"},   32'(bus.file_active), 32'd0);
    check({tag, " err@idle"},      32'(bus.error),       32'd0);
  endtask

  task automatic check_ptrs(input string tag, input logic [7:0] num,
                            input logic [31:0] rd, input logic [31:0] wr,
                            input logic [31:0] cnt);
    bus.file_num = num;
    #1;
    check({tag, " rd_ptr"},     bus.rd_ptr,            rd);
    check({tag, " wr_ptr"},     bus.wr_ptr,            wr);
    check({tag, " file_count"}, 32'(bus.file_count),   cnt);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.file_num           = 8'd0;
    bus.file_write         = 1'b0;
    bus.file_read          = 1'b0;
    bus.file_reset         = 1'b0;
    bus.file_rd_ptr_offset = 32'd0;
    bus.file_write_data    = 32'd0;
    bus.hold_rd_ptr        = 1'b0;
    step();
    step();
    check("rst active",    32'(bus.file_active), 32'd0);
    check("rst error",     32'(bus.error),       32'd0);
    check("rst read_data", bus.file_read_data,   32'd0);
    check_ptrs("rst f0", 8'd0, 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic write/read on file 1
    do_op("wr1a", 1'b1, 8'd1, 32'hA5A50001, 32'd0, 1'b0, 1'b0);
    do_op("wr1b", 1'b1, 8'd1, 32'hA5A50002, 32'd0, 1'b0, 1'b0);
    do_op("wr1c", 1'b1, 8'd1, 32'hA5A50003, 32'd0, 1'b0, 1'b0);
    check_ptrs("f1 after writes", 8'd1, 32'd0, 32'd3, 32'd3);
    do_op("rd1a", 1'b0, 8'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rd1a data", bus.file_read_data, 32'hA5A50001);
    do_op("rd1b", 1'b0, 8'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rd1b data", bus.file_read_data, 32'hA5A50002);
    do_op("rd1c", 1'b0, 8'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rd1c data", bus.file_read_data, 32'hA5A50003);
    check_ptrs("f1 after reads", 8'd1, 32'd3, 32'd3, 32'd0);
    check_ptrs("f0 untouched",   8'd0, 32'd0, 32'd0, 32'd0);

    // Fill file 0, then overflow
    for (int i = 0; i < 16; i++)
      do_op("fill0", 1'b1, 8'd0, 32'h100 + 32'(i), 32'd0, 1'b0, 1'b0);
    check_ptrs("f0 full", 8'd0, 32'd0, 32'd0, 32'd16);
    do_op("overflow", 1'b1, 8'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    check_ptrs("f0 after overflow", 8'd0, 32'd0, 32'd0, 32'd16);
    do_op("rd0 after full", 1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rd0 word0", bus.file_read_data, 32'h100);
    check_ptrs("f0 after read", 8'd0, 32'd1, 32'd0, 32'd15);

    // Peek with offset on file 2
    do_op("wr2a", 1'b1, 8'd2, 32'h10, 32'd0, 1'b0, 1'b0);
    do_op("wr2b", 1'b1, 8'd2, 32'h20, 32'd0, 1'b0, 1'b0);
    do_op("wr2c", 1'b1, 8'd2, 32'h30, 32'd0, 1'b0, 1'b0);
    do_op("peek2", 1'b0, 8'd2, 32'd0, 32'd2, 1'b1, 1'b0);
    check("peek2 data", bus.file_read_data, 32'h30);
    check_ptrs("f2 after peek", 8'd2, 32'd0, 32'd3, 32'd3);

    // Offset out of range
    do_op("off oor", 1'b0, 8'd2, 32'd0, 32'd3, 1'b0, 1'b1);
    check("off oor data", bus.file_read_data, 32'd0);
    check_ptrs("f2 after oor", 8'd2, 32'd0, 32'd3, 32'd3);

    // Empty file and illegal file number
    do_op("peek2 off0", 1'b0, 8'd2, 32'd0, 32'd0, 1'b1, 1'b0);
    check("peek2 off0 data", bus.file_read_data, 32'h10);
    do_op("rd empty3", 1'b0, 8'd3, 32'd0, 32'd0, 1'b0, 1'b1);
    check("rd empty3 data", bus.file_read_data, 32'd0);
    check_ptrs("f3 unchanged", 8'd3, 32'd0, 32'd0, 32'd0);
    do_op("peek2 off1", 1'b0, 8'd2, 32'd0, 32'd1, 1'b1, 1'b0);
    check("peek2 off1 data", bus.file_read_data, 32'h20);
    do_op("wr file5", 1'b1, 8'd5, 32'h12345678, 32'd0, 1'b0, 1'b1);
    check("wr file5 keeps data", bus.file_read_data, 32'h20);
    check_ptrs("file5 outputs", 8'd5, 32'd0, 32'd0, 32'd0);
    check_ptrs("f2 after file5", 8'd2, 32'd0, 32'd3, 32'd3);

    // Reset beats write on file 1 holding 2 words
    do_op("wr1d", 1'b1, 8'd1, 32'h11, 32'd0, 1'b0, 1'b0);
    do_op("wr1e", 1'b1, 8'd1, 32'h22, 32'd0, 1'b0, 1'b0);
    check_ptrs("f1 two words", 8'd1, 32'd3, 32'd5, 32'd2);
    bus.file_reset      = 1'b1;
    bus.file_write      = 1'b1;
    bus.file_write_data = 32'h99;
    step();
    bus.file_reset = 1'b0;
    bus.file_write = 1'b0;
    check("prio active", 32'(bus.file_active), 32'd0);
    check("prio error",  32'(bus.error),       32'd0);
    check_ptrs("f1 after reset", 8'd1, 32'd0, 32'd0, 32'd0);
    step();
    step();
    check("prio no write active", 32'(bus.file_active), 32'd0);
    check_ptrs("f1 still empty", 8'd1, 32'd0, 32'd0, 32'd0);

    // Write issued while busy is ignored
    bus.file_write      = 1'b1;
    bus.file_write_data = 32'h77;
    step();
    check("busy accept", 32'(bus.file_active), 32'd1);
    bus.file_write_data = 32'h88;
    step();
    bus.file_write = 1'b0;
    check("busy access", 32'(bus.file_active), 32'd1);
    step();
    check("busy done", 32'(bus.file_active), 32'd0);
    step();
    check("busy ignored active", 32'(bus.file_active), 32'd0);
    check_ptrs("f1 one word", 8'd1, 32'd0, 32'd1, 32'd1);
    do_op("rd busy word", 1'b0, 8'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rd busy word data", bus.file_read_data, 32'h77);
    check_ptrs("f1 drained", 8'd1, 32'd1, 32'd1, 32'd0);

    // Asynchronous reset during ACCEPT
    bus.file_write      = 1'b1;
    bus.file_write_data = 32'h55;
    step();
    check("rst mid accept", 32'(bus.file_active), 32'd1);
    rst_n          = 1'b0;
    bus.file_write = 1'b0;
    #1;
    check("rst mid active", 32'(bus.file_active), 32'd0);
    check("rst mid error",  32'(bus.error),       32'd0);
    check("rst mid data",   bus.file_read_data,   32'd0);
    check_ptrs("rst mid f1", 8'd1, 32'd0, 32'd0, 32'd0);
    check_ptrs("rst mid f0", 8'd0, 32'd0, 32'd0, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("after rst idle", 32'(bus.file_active), 32'd0);
    do_op("rd after rst", 1'b0, 8'd1, 32'd0, 32'd0, 1'b0, 1'b1);
    check("rd after rst data", bus.file_read_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
